// File: rtl/i2c_eeprom_pkg.sv
// Shared types and constants for the I2C EEPROM slave front end.
package i2c_eeprom_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        WADDR,
        WADDR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK
    } i2c_state_e;

    localparam logic [6:0] DEV_ADDR_DEF = 7'b1010000;
    localparam logic       RW_WRITE     = 1'b0;
    localparam logic       RW_READ      = 1'b1;
    localparam logic       ACK          = 1'b0;
    localparam logic       NACK         = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers, edge detection and START/STOP detection.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    // [0],[1] synchronize, [2] holds the previous synchronized value
    logic [2:0] scl_q;
    logic [2:0] sda_q;
    logic       scl_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    assign sda_s     = sda_q[1];
    assign scl_hi    = scl_q[1] & scl_q[2];
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_det = scl_hi & ~sda_q[1] & sda_q[2];
    assign stop_det  = scl_hi & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/i2c_eeprom_slave_ctrl.sv
// Bit-level I2C slave for a 24C02-style EEPROM: framing, ACK, read data
// and pointer/write strobes to the address-pointer stage.
module i2c_eeprom_slave_ctrl
    import i2c_eeprom_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
    parameter int         ADDR_W   = 8,
    parameter int         DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              ptr_load,
    output logic [ADDR_W-1:0] addr_o,
    output logic              ptr_inc,
    output logic              wr_en,
    output logic [DATA_W-1:0] wdata_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              busy
);

    i2c_state_e state, state_nx;

    logic       scl_rise, scl_fall, sda_s;
    logic       start_det, stop_det;
    logic [7:0] shreg, rx_byte, rd_byte;
    logic [3:0] bit_cnt;
    logic       mack;
    logic       rx_state, ack_state;
    logic       byte_done, ack_done, load_rd;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign rx_byte   = {shreg[6:0], sda_s};
    assign rd_byte   = 8'(rdata_i);
    assign rx_state  = state inside {DEV, WADDR, WDATA};
    assign ack_state = state inside {DEV_ACK, WADDR_ACK, WDATA_ACK};
    assign byte_done = rx_state && scl_rise && (bit_cnt == 4'd7);
    // sda_oe doubles as the ACK phase: first fall drives, second releases
    assign ack_done  = ack_state && scl_fall && sda_oe;
    assign load_rd   = (state == DEV_ACK && ack_done && shreg[0] == RW_READ)
                    || (state == RACK && scl_fall && mack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (stop_det) begin
            state_nx = IDLE;
        end else if (start_det) begin
            state_nx = DEV;
        end else begin
            unique case (state)
                DEV: if (byte_done)
                    state_nx = (shreg[6:0] == DEV_ADDR) ? DEV_ACK : IDLE;
                WADDR: if (byte_done) state_nx = WADDR_ACK;
                WDATA: if (byte_done) state_nx = WDATA_ACK;
                DEV_ACK: if (ack_done)
                    state_nx = (shreg[0] == RW_READ) ? RDATA : WADDR;
                WADDR_ACK, WDATA_ACK: if (ack_done) state_nx = WDATA;
                RDATA: if (scl_fall && bit_cnt == 4'd8) state_nx = RACK;
                RACK: begin
                    if (scl_rise && sda_s == NACK) state_nx = IDLE;
                    else if (scl_fall && mack)     state_nx = RDATA;
                end
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            mack     <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            ptr_load <= 1'b0;
            ptr_inc  <= 1'b0;
            wr_en    <= 1'b0;
            addr_o   <= '0;
            wdata_o  <= '0;
        end else begin
            ptr_load <= 1'b0;
            ptr_inc  <= 1'b0;
            wr_en    <= 1'b0;
            if (stop_det || start_det) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                mack    <= 1'b0;
                if (stop_det) busy <= 1'b0;
            end else if (load_rd) begin
                shreg   <= rd_byte;
                sda_oe  <= ~rd_byte[7];
                ptr_inc <= 1'b1;
                bit_cnt <= '0;
                mack    <= 1'b0;
            end else if (rx_state && scl_rise) begin
                shreg   <= rx_byte;
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd7) begin
                    if (state == WADDR) begin
                        ptr_load <= 1'b1;
                        addr_o   <= ADDR_W'(rx_byte);
                    end
                    if (state == WDATA) begin
                        wr_en   <= 1'b1;
                        wdata_o <= DATA_W'(rx_byte);
                    end
                    if (state == DEV && shreg[6:0] != DEV_ADDR)
                        busy <= 1'b0;
                end
            end else if (ack_state && scl_fall) begin
                sda_oe <= ~sda_oe;
                if (!sda_oe && state == DEV_ACK) busy <= 1'b1;
                if (sda_oe) begin
                    bit_cnt <= '0;
                    if (state == WDATA_ACK) ptr_inc <= 1'b1;
                end
            end else if (state == RDATA && scl_rise) begin
                bit_cnt <= bit_cnt + 4'd1;
            end else if (state == RDATA && scl_fall) begin
                if (bit_cnt == 4'd8) begin
                    sda_oe <= 1'b0;
                end else begin
                    shreg  <= {shreg[6:0], 1'b0};
                    sda_oe <= ~shreg[6];
                end
            end else if (state == RACK && scl_rise) begin
                if (sda_s == ACK) mack <= 1'b1;
                else              busy <= 1'b0;
            end
        end
    end

endmodule

// File: doc/i2c_eeprom_slave_ctrl.md
Name: i2c_eeprom_slave_ctrl

Overview:
- Bit-level I2C slave front end for the EEPROM model; sits directly upstream of the address-pointer/data-word stage.
- Oversamples SCL/SDA on the system clock, detects START/STOP, deserializes bytes and matches the device address.
- Drives SDA ACK and read data, and issues pointer load/increment strobes and write strobes to the downstream stage.
- Implements 24C02-style byte write, page write, current-address read, random read (repeated START) and sequential read.

Parameters:
- DEV_ADDR, 7'b1010000, 7-bit I2C device address matched against the first byte.
- ADDR_W, 8, word-address width (pointer load width).
- DATA_W, 8, data byte width; fixed at 8 for I2C, exposed for package consistency.

Ports:
- clk  in  1  system clock, >= 8x SCL.
- rst  in  1  asynchronous, active-high reset.
- scl_i  in  1  raw SCL, asynchronous to clk.
- sda_i  in  1  raw SDA, asynchronous to clk.
- sda_oe  out  1  1 = pull SDA low (open drain); 0 = release.
- ptr_load  out  1  one-clk pulse: load pointer with addr_o.
- addr_o  out  ADDR_W  word address received; valid while ptr_load = 1.
- ptr_inc  out  1  one-clk pulse: advance pointer by 1.
- wr_en  out  1  one-clk pulse: write wdata_o at the current pointer.
- wdata_o  out  DATA_W  received write byte; valid while wr_en = 1.
- rdata_i  in  DATA_W  byte at the current pointer, from downstream; combinational.
- busy  out  1  1 while addressed, from the ACK of the device byte until STOP or NACK.

Behaviour:
- Synchronization: SCL and SDA each pass through a 2-flop synchronizer plus a history flop. scl_rise, scl_fall, sda_rise and sda_fall are derived from the synchronized signals only.
- START: sda_fall while SCL is high. STOP: sda_rise while SCL is high. Both take priority over data sampling in the same clk.
- Data timing: SDA is sampled on scl_rise. sda_oe changes only on scl_fall, except STOP/START/reset, which release it immediately.
- Byte framing: bit counter counts 0..8. Bits 0-7 are MSB first; bit 8 is the ACK slot.
- States: IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
  - IDLE: START -> DEV. All other events are ignored.
  - DEV: after 8 bits, if byte[7:1] == DEV_ADDR -> DEV_ACK; otherwise -> IDLE with no ACK.
  - DEV_ACK: assert sda_oe for the 9th SCL period. Set busy at the scl_fall that asserts ACK. On the 9th scl_fall, go to WADDR if rw = 0, or RDATA if rw = 1.
  - WADDR: after 8 bits -> WADDR_ACK. ptr_load pulses on the 8th scl_rise + 1 clk, with addr_o = byte. Pointer semantics downstream: load sets {page, cnt}.
  - WADDR_ACK: ACK, then -> WDATA.
  - WDATA: after 8 bits -> WDATA_ACK. wr_en pulses with wdata_o on the 8th scl_rise + 1 clk.
  - WDATA_ACK: ACK. ptr_inc pulses at the 9th scl_fall. Then -> WDATA.
  - RDATA: on entry (the 9th scl_fall), capture rdata_i into the shift register and drive bit 7 immediately. ptr_inc pulses 1 clk after capture. On each subsequent scl_fall, shift: sda_oe = ~shreg[7]. After 8 bits, release SDA -> RACK.
  - RACK: at the 9th scl_rise, SDA = 0 (master ACK) -> RDATA (recapture at the next scl_fall). SDA = 1 (NACK) -> IDLE and clear busy.
- Repeated START in any state: abort the byte, clear the bit counter, release SDA -> DEV. No strobes are issued for the partial byte. The pointer is kept, which gives random read.
- STOP in any state: -> IDLE, release SDA, clear busy. A partial byte is discarded.
- Counter wrap: 8-bit address wrap is the downstream stage's responsibility. This block only pulses.
- Strobe rules: ptr_load, ptr_inc and wr_en are mutually exclusive and never asserted in the same clk.
- Reset: asynchronous, may arrive mid-transfer. All outputs = 0, addr_o = 0, wdata_o = 0, state = IDLE, bit counter = 0.

Decomposition:
- Shared package i2c_eeprom_pkg:
  - state enum.
  - DEV_ADDR default.
  - RW_WRITE/RW_READ constants.
  - ACK = 1'b0, NACK = 1'b1.
- One sub-module i2c_bus_sync: synchronizers, edge detect and START/STOP detect. Outputs scl_rise, scl_fall, sda_s, start_det, stop_det.
- The FSM, shift register and bit counter stay in the top module.

Test Plan:
- Byte write: START, 0xA0, 0x3C, 0x55, STOP.
  - ACKs on all three bytes.
  - ptr_load once with addr_o = 0x3C; wr_en once with wdata_o = 0x55; ptr_inc once.
  - busy falls at STOP.
- Address mismatch: START, 0xA2, 0x10, STOP.
  - sda_oe stays 0 for the whole transfer; no strobes; busy stays 0.
- Random read: START, 0xA0, 0x07, repeated START, 0xA1; rdata_i = 0xC3, then 0x5A; master ACK, then NACK, then STOP.
  - ptr_load with addr_o = 0x07.
  - SDA bits read back 11000011 then 01011010; two ptr_inc pulses.
  - State = IDLE after the NACK.
- Page write of 4 bytes (0x01..0x04) to address 0xF8: wr_en four times with the data in order; ptr_inc four times; no ptr_load after the first.
- STOP after 4 data bits of a write byte: no wr_en or ptr_inc, sda_oe = 0, state IDLE. The next START, 0xA0 is ACKed normally.
- rst asserted while sda_oe = 1 during DEV_ACK: sda_oe = 0 and busy = 0 in the same clk without waiting for a clock edge. After release, the next transaction completes correctly.
